// File: rtl/gsr_seq_if.sv
// Status/control bundle for the global reset sequencer: lock and soft-reset
// inputs toward the sequencer, staggered resets and status back out.
interface gsr_seq_if #(
    parameter int CHANNELS = 4
);
    logic                LOCK;
    logic                SRST_REQ;
    logic [CHANNELS-1:0] RSTN_OUT;
    logic                READY;
    logic [2:0]          STATE;

    // Environment side: drives lock/soft-reset, observes the reset outputs.
    modport master (
        output LOCK,
        output SRST_REQ,
        input  RSTN_OUT,
        input  READY,
        input  STATE
    );

    // Sequencer side.
    modport slave (
        input  LOCK,
        input  SRST_REQ,
        output RSTN_OUT,
        output READY,
        output STATE
    );
endinterface

// File: rtl/gsr_seq.sv
// Global set/reset sequencer. Holds every channel in reset while GSR is low,
// waits for a synchronised GSR release and clock lock, stretches for STRETCH
// cycles, then releases the channels one by one, STAGGER cycles apart.
// Lock loss or a soft-reset request drops all channels and restarts the wait.
module gsr_seq #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 4
) (
    input  logic       CLK,
    input  logic       GSR,
    gsr_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STRETCH   = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int MAX_COUNT = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam int IW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CW-1:0]       STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0]       STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW:0]         LAST_IDX     = (IW + 1)'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] FIRST_BIT    = CHANNELS'(1);

    logic [SYNC_STAGES-1:0] gsrSync_q;
    logic [SYNC_STAGES-1:0] lockSync_q;
    logic                   gsrS;
    logic                   lockS;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CHANNELS-1:0] rstn_q, rstn_d;
    logic                ready_q;
    logic [IW:0]         nextIdx;
    logic                abortSeq;

    // GSR release and LOCK are brought into the clock domain through equal-depth chains.
    always_ff @(posedge CLK or negedge GSR) begin
        if (!GSR) begin
            gsrSync_q  <= '0;
            lockSync_q <= '0;
        end else begin
            gsrSync_q  <= {gsrSync_q[SYNC_STAGES-2:0], 1'b1};
            lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], bus.LOCK};
        end
    end

    assign gsrS  = gsrSync_q[SYNC_STAGES-1];
    assign lockS = lockSync_q[SYNC_STAGES-1];

    // A soft reset anywhere past HOLD, or lock loss once sequencing has begun, restarts the wait.
    assign abortSeq = (state_q inside {ST_WAIT_LOCK, ST_STRETCH, ST_RELEASE, ST_RUN}) &&
                      (bus.SRST_REQ ||
                       (!lockS && (state_q inside {ST_STRETCH, ST_RELEASE, ST_RUN})));

    // Next-state, counter, channel index and release mask; unused codes fall back to HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rstn_d  = rstn_q;
        nextIdx = {1'b0, idx_q} + (IW + 1)'(1);
        if (abortSeq) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rstn_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rstn_d = '0;
                    if (gsrS) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    rstn_d = '0;
                    cnt_d  = '0;
                    idx_d  = '0;
                    if (lockS) state_d = ST_STRETCH;
                end
                ST_STRETCH: begin
                    if (cnt_q == STRETCH_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        rstn_d  = FIRST_BIT;
                        state_d = (CHANNELS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d  = '0;
                        idx_d  = nextIdx[IW-1:0];
                        rstn_d = rstn_q | (FIRST_BIT << nextIdx);
                        if (nextIdx == LAST_IDX) state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rstn_d = '1;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rstn_d  = '0;
                end
            endcase
        end
    end

    // Sequencer registers; READY trails RUN by one edge so it only reports a settled sequence.
    always_ff @(posedge CLK or negedge GSR) begin
        if (!GSR) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rstn_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rstn_q  <= rstn_d;
            ready_q <= (state_q == ST_RUN);
        end
    end

    assign bus.RSTN_OUT = rstn_q;
    assign bus.READY    = ready_q;
    assign bus.STATE    = state_q;

endmodule
